// File: rtl/data_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Optional build macro DATA_MEM_ARB_RANGE_CHECK_EN flags grants whose address is >= MEM_DEPTH.
module data_mem_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              busy,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memWriteData,
  output logic              memRead,
  output logic              memWrite,
  input  logic [DATA_W-1:0] memReadData
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;

  // Candidate grantee: the sole requester, or on a tie the one not granted last.
  logic                pick;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  always_comb begin
    pick      = (req0 && req1) ? ~last_grant_q : req1;
    sel_we    = pick ? we1 : we0;
    sel_addr  = pick ? addr1 : addr0;
    sel_wdata = pick ? wdata1 : wdata0;
  end

`ifdef DATA_MEM_ARB_RANGE_CHECK_EN
  logic oor_q, oor_d;
  logic err0_q, err0_d;
  logic err1_q, err1_d;
  logic sel_oor;

  assign sel_oor = (32'(sel_addr) >= 32'(MEM_DEPTH));
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    we_d          = we_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
`ifdef DATA_MEM_ARB_RANGE_CHECK_EN
    oor_d         = oor_q;
    err0_d        = 1'b0;
    err1_d        = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d       = ACCESS;
          grant_d       = pick;
          last_grant_d  = pick;
          we_d          = sel_we;
          mem_address_d = sel_addr;
          mem_wdata_d   = sel_wdata;
`ifdef DATA_MEM_ARB_RANGE_CHECK_EN
          oor_d         = sel_oor;
          mem_write_d   = sel_we && !sel_oor;
          mem_read_d    = !sel_we && !sel_oor;
`else
          mem_write_d   = sel_we;
          mem_read_d    = !sel_we;
`endif
        end
      end

      ACCESS: begin
        state_d = DONE;
        ack0_d  = !grant_q;
        ack1_d  = grant_q;
`ifdef DATA_MEM_ARB_RANGE_CHECK_EN
        // A range-rejected access completes with an error and a cleared result.
        if (oor_q) begin
          err0_d = !grant_q;
          err1_d = grant_q;
          if (grant_q) rdata1_d = '0;
          else         rdata0_d = '0;
        end else
`endif
        if (!we_q) begin
          if (grant_q) rdata1_d = memReadData;
          else         rdata0_d = memReadData;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state_q       <= IDLE;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      we_q          <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
`ifdef DATA_MEM_ARB_RANGE_CHECK_EN
      oor_q         <= 1'b0;
      err0_q        <= 1'b0;
      err1_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      we_q          <= we_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
`ifdef DATA_MEM_ARB_RANGE_CHECK_EN
      oor_q         <= oor_d;
      err0_q        <= err0_d;
      err1_q        <= err1_d;
`endif
    end
  end

  assign busy         = (state_q != IDLE);
  assign memAddress   = mem_address_q;
  assign memWriteData = mem_wdata_q;
  assign memRead      = mem_read_q;
  assign memWrite     = mem_write_q;
  assign ack0         = ack0_q;
  assign ack1         = ack1_q;
  assign rdata0       = rdata0_q;
  assign rdata1       = rdata1_q;

`ifdef DATA_MEM_ARB_RANGE_CHECK_EN
  assign err0 = err0_q;
  assign err1 = err1_q;
`else
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 10, requester and memory address width.
REQ-002 Parameter: DATA_W, 16, data word width.
REQ-003 Parameter: MEM_DEPTH, 1000, number of valid memory words (addresses 0..MEM_DEPTH-1).
REQ-004 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port: rst  input  1  synchronous active-low reset, sampled on rising clk.
REQ-006 Port: req0, req1  input  1 each  access request from requester 0 / 1.
REQ-007 Port: we0, we1  input  1 each  1 = write, 0 = read; held with reqN.
REQ-008 Port: addr0, addr1  input  ADDR_W each  word address; held with reqN.
REQ-009 Port: wdata0, wdata1  input  DATA_W each  write data; held with reqN.
REQ-010 Port: ack0, ack1  output  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-011 Port: rdata0, rdata1  output  DATA_W each  read result, valid from the ack cycle until that requester's next ack.
REQ-012 Port: err0, err1  output  1 each  out-of-range flag, pulsed with ackN.
REQ-013 Port: busy  output  1  high whenever the FSM is not IDLE.
REQ-014 Port: memAddress  output  ADDR_W  registered address to data memory.
REQ-015 Port: memWriteData  output  DATA_W  registered write data to data memory.
REQ-016 Port: memRead, memWrite  output  1 each  memory strobes; the memory acts on strobe edges, so each strobe SHALL be a single-cycle high pulse preceded and followed by low.
REQ-017 Port: memReadData  input  DATA_W  data memory read output.

Function
REQ-018 FSM states: IDLE, ACCESS, DONE; transitions only on rising clk.
REQ-019 IDLE: no req -> stay IDLE; any req -> ACCESS, latch grantee, drive memAddress/memWriteData from grantee's addr/wdata, assert memWrite if weN else memRead.
REQ-020 ACCESS -> DONE unconditionally: strobes low; for reads, grantee's rdata latches memReadData; ackN high for the DONE cycle only.
REQ-021 DONE -> IDLE unconditionally: ackN low; requests are re-arbitrated only on an edge where state is IDLE.
REQ-022 Latency: req sampled at edge E0 -> strobe high E0..E1 -> ack high E1..E2 -> IDLE at E2; peak throughput one access per 3 cycles.
REQ-023 Handshake: requester holds req/we/addr/wdata stable until ack and drops req the edge after ack; req still high at the next IDLE edge is a new access.
REQ-024 Arbitration: sole requester wins; if both request, grant the one not granted last (round-robin via last_grant bit, updated on each grant).
REQ-025 The losing requester's req is ignored until its grant; no ack, no data change for it.
REQ-026 Write accesses leave rdataN unchanged; at most one strobe is high in any cycle.
REQ-027 memAddress/memWriteData hold their last values outside ACCESS.

Reset
REQ-028 rst low at an edge: state=IDLE, strobes=0, ack0/1=0, err0/1=0, busy=0, rdata0/1=0, memAddress=0, memWriteData=0, last_grant=1 (requester 0 wins first tie).
REQ-029 Reset mid-access aborts: no ack issued for the aborted access; strobes low from the reset edge.

Configuration
REQ-030 Macro DATA_MEM_ARB_RANGE_CHECK_EN defined: grant with addr >= MEM_DEPTH skips strobes, goes ACCESS->DONE with errN=1 and ackN=1, rdataN=0.
REQ-031 Macro undefined: no range check; all addresses strobed; err0/err1 tied to 0.

Verification
REQ-032 Reset, then req0 read addr 500 -> memRead pulse one cycle, ack0 two edges after sampling, rdata0=16'h0001.
REQ-033 req1 write addr 505 data 16'h00AA, then req1 read addr 505 -> memWrite pulse, ack1, then rdata1=16'h00AA.
REQ-034 req0 and req1 rise on same edge after reset -> requester 0 served first, requester 1 acked 3 cycles later; repeat -> order alternates.
REQ-035 rst low during ACCESS -> strobes 0 next cycle, no ack, busy=0; later req0 read addr 501 -> rdata0=16'h0002.
REQ-036 With DATA_MEM_ARB_RANGE_CHECK_EN, req0 read addr 1000 -> no strobe, ack0=1, err0=1, rdata0=0; without macro -> memRead pulses, err0=0.
